// File: rtl/cle_seq_pkg.sv
// Shared definitions for the CLE361 key/lock sequencer.
//
// Contents:
//   seq_state_e  - sequencer FSM states
//   LOCK_BA13    - BA13 level that selects the lock region
//   LOCK_BA12    - BA12 level that selects the lock region
//   RESYNC_NIB   - nibble sent on the lock resync strobe; also the
//                  parked value of BA7..BA4 while the bus is not owned
//   idx_width()  - width of the strobe index counter
package cle_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } seq_state_e;

  localparam logic       LOCK_BA13  = 1'b0;
  localparam logic       LOCK_BA12  = 1'b1;
  localparam logic [3:0] RESYNC_NIB = 4'h0;

  // The index must be able to hold SEQ_LEN itself, which is the
  // saturated "all nibbles sent" value.
  function automatic int idx_width(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/cle_bus_arb.sv
// Lock bus arbiter between the host and the key sequencer.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   host_req_i   host wants the lock bus
//   seq_want_i   sequencer wants to own the bus in the next cycle
//   bus_free_o   host is neither requesting nor holding the bus
//   host_gnt_o   registered: host owns the bus
//   bus_own_o    registered: sequencer owns the bus
//
// A new sequencer ownership is only granted when the host is fully off
// the bus (request low and grant already dropped), so an in-flight host
// cycle is never preempted. Once owned, the sequencer keeps the bus for
// as long as it asks; host requests in that window are held off. Both
// grants are derived from the same next-state, so they can never be high
// together.
module cle_bus_arb (
  input  logic clk_i,
  input  logic rst_i,
  input  logic host_req_i,
  input  logic seq_want_i,
  output logic bus_free_o,
  output logic host_gnt_o,
  output logic bus_own_o
);

  logic host_gnt_q, host_gnt_d;
  logic bus_own_q, bus_own_d;

  assign bus_free_o = !host_req_i && !host_gnt_q;

  always_comb begin
    bus_own_d  = seq_want_i && (bus_own_q || bus_free_o);
    host_gnt_d = host_req_i && !bus_own_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      host_gnt_q <= 1'b0;
      bus_own_q  <= 1'b0;
    end else begin
      host_gnt_q <= host_gnt_d;
      bus_own_q  <= bus_own_d;
    end
  end

  assign host_gnt_o = host_gnt_q;
  assign bus_own_o  = bus_own_q;

endmodule

// File: rtl/cle_key_sequencer.sv
// Bus-side sequencer for the CLE361 key/lock PAL.
//
// Takes the lock bus from the host, sends SEQ_LEN key nibbles on BA7..BA4
// (one single-cycle SSER strobe each, BA13=0/BA12=1/BR_W=1), samples SDRD
// on each strobe closing edge into resp, then hands the bus back.
//
// Parameters:
//   SEQ_LEN     nibbles per sequence (2..16)
//   GAP_CYCLES  idle cycles between strobes (1..15)
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              pulse, begins a sequence (IDLE only)
//   abort_i              level, ends the sequence at the next strobe boundary
//   key_i                nibble list, nibble 0 = key_i[3:0] sent first
//   expect_i             expected response (verify build only)
//   host_req_i           host wants the lock bus
//   host_gnt_o           host owns the bus
//   bus_own_o            sequencer drives BA*/SSER/BR_W
//   sser_n_o             lock select, active low
//   ba13_o, ba12_o       region select
//   ba_nib_o             BA7..BA4
//   br_w_o               read strobe (1 = read)
//   sdrd_i               lock data bit
//   busy_o               sequence in progress
//   done_o               one-cycle completion pulse
//   resp_o               collected SDRD bits, bit i = strobe i
//   err_o                sticky until next start: abort or verify mismatch
//   dbg_state_o          current FSM state (seq_state_e encoding)
//
// Build option CLE_SEQ_VERIFY_EN: compare resp against expect_i at the end;
// on mismatch send one extra resync strobe with RESYNC_NIB and set err.
//
// Handshake: start_i is a one-cycle request honoured only in IDLE; done_o
// is a one-cycle pulse in the FINISH cycle, when busy_o drops. All outputs
// are registered and align with the state they describe.
module cle_key_sequencer
  import cle_seq_pkg::*;
#(
  parameter int SEQ_LEN    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [4*SEQ_LEN-1:0] key_i,
  input  logic [SEQ_LEN-1:0]   expect_i,
  input  logic                 host_req_i,
  output logic                 host_gnt_o,
  output logic                 bus_own_o,
  output logic                 sser_n_o,
  output logic                 ba13_o,
  output logic                 ba12_o,
  output logic [3:0]           ba_nib_o,
  output logic                 br_w_o,
  input  logic                 sdrd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SEQ_LEN-1:0]   resp_o,
  output logic                 err_o,
  output logic [2:0]           dbg_state_o
);

  localparam int IDX_W = idx_width(SEQ_LEN);

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           gap_q, gap_d;
  logic [4*SEQ_LEN-1:0] key_q, key_d;
  logic [SEQ_LEN-1:0]   resp_q, resp_d;
  logic                 err_q, err_d;

  logic       sser_n_q, sser_n_d;
  logic       ba13_q, ba13_d;
  logic       ba12_q, ba12_d;
  logic [3:0] ba_nib_q, ba_nib_d;
  logic       br_w_q;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       own_next;
  logic       bus_free;
  logic [3:0] nib_sel;

`ifdef CLE_SEQ_VERIFY_EN
  logic resync_q, resync_d;
  logic mismatch;
  assign mismatch = (resp_q != expect_i);
`else
  logic unused_expect;
  assign unused_expect = ^expect_i;
`endif

  cle_bus_arb u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .host_req_i (host_req_i),
    .seq_want_i (own_next),
    .bus_free_o (bus_free),
    .host_gnt_o (host_gnt_o),
    .bus_own_o  (bus_own_o)
  );

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    key_d   = key_q;
    resp_d  = resp_q;
    err_d   = err_q;
`ifdef CLE_SEQ_VERIFY_EN
    resync_d = resync_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d   = key_i;
          resp_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
`ifdef CLE_SEQ_VERIFY_EN
          resync_d = 1'b0;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_free) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        // Saturated index means a resync strobe: nothing is recorded.
        if (idx_q != IDX_W'(SEQ_LEN)) begin
          for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx_q == IDX_W'(i)) resp_d[i] = sdrd_i;
          end
          idx_d = idx_q + IDX_W'(1);
        end
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (gap_q == 4'(GAP_CYCLES - 1)) begin
          if (idx_q != IDX_W'(SEQ_LEN)) begin
            state_d = S_SETUP;
          end
`ifdef CLE_SEQ_VERIFY_EN
          else if (!resync_q && mismatch) begin
            resync_d = 1'b1;
            state_d  = S_SETUP;
          end
`endif
          else begin
            state_d = S_FINISH;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_FINISH: begin
`ifdef CLE_SEQ_VERIFY_EN
        err_d = err_q | mismatch;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Nibble for the next SETUP. idx has already advanced on the previous
  // strobe edge, so idx_q points at the nibble about to be sent.
  always_comb begin
    nib_sel = RESYNC_NIB;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) nib_sel = key_q[4*i +: 4];
    end
`ifdef CLE_SEQ_VERIFY_EN
    if (resync_d) nib_sel = RESYNC_NIB;
`endif
  end

  // Outputs are computed from the next state and registered, so each
  // output value lines up with the state it belongs to.
  always_comb begin
    own_next = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_GAP);
    sser_n_d = (state_d != S_STROBE);
    ba13_d   = own_next ? LOCK_BA13 : 1'b0;
    ba12_d   = own_next ? LOCK_BA12 : 1'b0;
    ba_nib_d = RESYNC_NIB;
    if (state_d == S_SETUP) ba_nib_d = nib_sel;
    else if (own_next)      ba_nib_d = ba_nib_q;
    busy_d   = own_next || (state_d == S_REQ);
    done_d   = (state_d == S_FINISH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      key_q    <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
      sser_n_q <= 1'b1;
      ba13_q   <= 1'b0;
      ba12_q   <= 1'b0;
      ba_nib_q <= 4'h0;
      br_w_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      key_q    <= key_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      sser_n_q <= sser_n_d;
      ba13_q   <= ba13_d;
      ba12_q   <= ba12_d;
      ba_nib_q <= ba_nib_d;
      br_w_q   <= 1'b1;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef CLE_SEQ_VERIFY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) resync_q <= 1'b0;
    else       resync_q <= resync_d;
  end
`endif

  assign sser_n_o    = sser_n_q;
  assign ba13_o      = ba13_q;
  assign ba12_o      = ba12_q;
  assign ba_nib_o    = ba_nib_q;
  assign br_w_o      = br_w_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign resp_o      = resp_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
